imem_loader: RTL
================

# imem_loader

Byte-stream program loader: the write-side counterpart of the instruction memory that the PC/decoder path reads. It accepts a length-prefixed byte stream over a valid/ready handshake and packs byte pairs into 11-bit instruction words (opcode/op1/op2/type format). It writes those words sequentially into instruction memory and holds the CPU core in reset until a load completes successfully. It sits between a host/serial front end and the instruction memory write port.

## Interface
- BASE_ADDR, 8'h00, instruction-memory address of the first loaded word.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load session; honoured only in IDLE.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader can accept a byte; a byte transfers on a rising edge with in_valid && in_ready.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  8  write address.
- wr_data  out  11  write word.
- cpu_reset  out  1  hold-reset to PC/decoder/ALU.
- busy  out  1  load session in progress.
- done  out  1  one-cycle end-of-session pulse, pass or fail.
- err  out  1  sticky checksum failure; cleared by the next accepted start.

## Operation
- States:
  - IDLE -> LEN on start.
  - LEN: accept count N. N=0 goes to END (or CHK); otherwise goes to LO.
  - LO: accept low byte, goes to HI.
  - HI: accept high byte; goes to LO if words remain, otherwise END (or CHK).
  - CHK: accept checksum byte (macro only), goes to END.
  - END -> IDLE.
- Stream format: N (0..255), then N pairs {lo, hi}. wr_data = {hi[2:0], lo}; hi[7:3] ignored.
- Word index i counts 0..N-1. wr_addr = (BASE_ADDR + i) mod 256; wraps from 8'hFF to 8'h00.
- in_ready = 1 in LEN, LO, HI, CHK; 0 in IDLE, END, and after reset. Bytes offered in IDLE are not consumed.
- busy = 1 in every state except IDLE.
- cpu_reset:
  - 1 out of reset and throughout any session.
  - Cleared in the END cycle of a successful session.
  - Stays 1 after a failed session.
  - Goes back to 1 on the next accepted start.
- start while busy is ignored. start in the END cycle is ignored.
- Reset mid-session: abandon the session, return to IDLE, drive all reset values. Words already written stay in memory. The next start restarts at i=0.

## Timing
- Reset values: in_ready 0, wr_en 0, wr_addr 8'h00, wr_data 11'h000, cpu_reset 1, busy 0, done 0, err 0.
- start sampled at cycle t: state is LEN and in_ready = 1 at t+1.
- HI byte accepted at edge t: wr_en = 1 with wr_addr/wr_data valid during cycle t+1 only. All write outputs are registered. wr_addr/wr_data hold between strobes.
- Last HI byte (or N=0 LEN byte, or CHK byte) accepted at edge t:
  - END during t+1: done = 1, busy = 1, cpu_reset per result, err updated.
  - IDLE at t+2.
- Peak throughput is one byte per cycle. in_valid gaps stall the FSM without side effects.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last pair (or after LEN when N=0), the FSM enters CHK and accepts one trailing byte.
  - Pass requires the trailing byte to equal the XOR of all preceding session bytes, including N.
  - Mismatch: err = 1 in END, cpu_reset stays 1, done still pulses.
- Undefined: no CHK state, no trailing byte, err is tied to 0, and every completed session passes.

## Test plan
- Basic load, BASE_ADDR=0, after reset: start, stream 02,05,01,0A,07.
  - wr_en twice: (00, 11'h105) then (01, 11'h70A).
  - done pulses once; cpu_reset falls in the done cycle; busy 0 next cycle.
- Backpressure and gaps: same stream with in_valid low 3 cycles between bytes, and a byte held valid before start -> identical writes; pre-start byte not consumed (in_ready 0 in IDLE).
- Empty and wrap:
  - N=00 -> no wr_en, done two cycles after start edge, cpu_reset 0.
  - BASE_ADDR=8'hFE, N=03 -> addresses FE, FF, 00.
- Reset mid-session: assert reset after bytes 02,05,01 (one write done) -> next cycle all outputs at reset values; a fresh start/stream rewrites from BASE_ADDR.
- Checksum (macro defined): stream 01,34,02 then 37 -> write (00, 11'h234), done, err 0, cpu_reset 0. Same stream with trailing 00 -> err 1, cpu_reset 1, done pulses. Next start clears err.
- Busy start: pulse start mid-session -> ignored; session completes with the original N.

Source files
------------

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Byte-stream program loader for the instruction memory. It accepts a
// length-prefixed byte stream on a valid/ready handshake and packs each
// {lo, hi} byte pair into an 11-bit instruction word {hi[2:0], lo}. Each
// word is written to consecutive instruction-memory addresses, starting
// at BASE_ADDR and wrapping modulo 256. The CPU core is held in reset
// until a load session completes successfully.
//
// Stream format: N (0..255), then N pairs {lo, hi}, then one checksum byte
// if the checksum option is built in.
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  When defined, each session ends with one
//                            trailing byte. That byte must equal the XOR
//                            of every earlier session byte, including N.
//                            A mismatch sets err and leaves cpu_reset_o
//                            asserted. When undefined, err_o is tied to 0
//                            and every completed session passes.
//
// Parameters:
//   BASE_ADDR    instruction-memory address of word 0
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      single-cycle load request, honoured only in IDLE
//   in_valid_i   input byte valid
//   in_data_i    input byte
//   in_ready_o   loader can accept a byte this cycle
//   wr_en_o      instruction-memory write strobe, one cycle per word
//   wr_addr_o    write address (holds between strobes)
//   wr_data_o    write word (holds between strobes)
//   cpu_reset_o  hold-reset for the PC/decoder/ALU path
//   busy_o       load session in progress
//   done_o       single-cycle end-of-session pulse, pass or fail
//   err_o        sticky checksum failure, cleared by the next accepted start
// ---------------------------------------------------------------------------
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i, no bytes consumed
// LEN   | accepting word count N
// LO    | accepting low byte of the current word
// HI    | accepting high byte; issues the memory write
// CHK   | accepting the trailing checksum byte (checksum build only)
// END   | done_o pulse, pass/fail result applied; back to IDLE next

module imem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        wr_en_o,
  output logic [7:0]  wr_addr_o,
  output logic [10:0] wr_data_o,
  output logic        cpu_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_CHK  = 3'd4,
    S_END  = 3'd5
  } state_t;

  // The state entered after the last data byte, or after LEN when N=0.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_END;
`endif

  state_t      state_q, state_d;
  logic        in_ready_q;
  logic        busy_q;
  logic        done_q;
  logic        cpu_reset_q;
  logic        wr_en_q;
  logic [7:0]  wr_addr_q;
  logic [10:0] wr_data_q;
  logic [7:0]  cnt_q;       // words still to receive, down-counter
  logic [7:0]  idx_q;       // word index within the session
  logic [7:0]  lo_q;        // low byte waiting for its high byte
  logic        xfer;
  logic        start_ok;
  logic        sess_pass;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
  logic        err_q;
`endif

  assign xfer     = in_valid_i && in_ready_q;
  assign start_ok = (state_q == S_IDLE) && start_i;

  // Result of the session that is about to enter END.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign sess_pass = (in_data_i == csum_q);
`else
  assign sess_pass = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_LEN;
      S_LEN: begin
        if (xfer) state_d = (in_data_i == 8'd0) ? S_TAIL : S_LO;
      end
      S_LO:  if (xfer) state_d = S_HI;
      S_HI: begin
        // Terminal count: the pair just completed was the last one.
        if (xfer) state_d = (cnt_q == 8'd1) ? S_TAIL : S_LO;
      end
      S_CHK: if (xfer) state_d = S_END;
      S_END: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 11'h000;
      cnt_q       <= 8'd0;
      idx_q       <= 8'd0;
      lo_q        <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      // Handshake/status outputs are decoded from the next state so they
      // line up with the state register rather than lagging it.
      in_ready_q <= (state_d == S_LEN) || (state_d == S_LO) ||
                    (state_d == S_HI)  || (state_d == S_CHK);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_END);
      wr_en_q    <= 1'b0;

      if (start_ok) begin
        idx_q       <= 8'd0;
        cpu_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q      <= 8'd0;
        err_q       <= 1'b0;
`endif
      end

      if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ in_data_i;
`endif
        case (state_q)
          S_LEN: cnt_q <= in_data_i;
          S_LO:  lo_q  <= in_data_i;
          S_HI: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= BASE_ADDR + idx_q;
            wr_data_q <= {in_data_i[2:0], lo_q};
            idx_q     <= idx_q + 8'd1;
            cnt_q     <= cnt_q - 8'd1;
          end
          default: ;
        endcase
      end

      // Only a checksum byte can carry a failing result; every other path
      // into END is a pass.
      if (state_d == S_END) begin
        if (state_q == S_CHK) begin
          cpu_reset_q <= !sess_pass;
`ifdef IMEM_LOADER_CHECKSUM_EN
          err_q       <= !sess_pass;
`endif
        end else begin
          cpu_reset_q <= 1'b0;
        end
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cpu_reset_o = cpu_reset_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule
